// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter
//   Shares an 8-digit multiplexed 7-segment scanner between two sources.
//   Source A is a persistent value. Source B is a transient message that
//   preempts A for HOLD_TICKS prescaler ticks. After that the display
//   reverts to the latest A value. The selected 32-bit hex word is encoded
//   into active-low segment bytes with leading-zero suppression. The
//   significant-digit count is reported to the scanner.
//
//   Optional feature macro: SEG_BLINK_EN
//     When defined, a source-B message blinks with a half-period of
//     BLINK_TICKS ticks. It starts in the on phase.
//
// Ports
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   a_valid  in   source A word offered
//   a_ready  out  source A accept (always 1)
//   a_data   in   source A value, nibble 0 = rightmost digit
//   b_valid  in   source B message offered
//   b_ready  out  source B accept (high only while A is displayed)
//   b_data   in   source B value
//   signal   out  segment bytes, byte k = digit k, active-low {dp,g..a}
//   n        out  digit count to the scanner (1..7)
//   src      out  0 = A displayed, 1 = B displayed
//   ovf      out  value has 8 significant digits; the MSD is not shown
module seg_disp_arbiter #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 2000
`ifdef SEG_BLINK_EN
  ,
  parameter int unsigned BLINK_TICKS = 250
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_data,
  output logic [63:0] signal,
  output logic [2:0]  n,
  output logic        src,
  output logic        ovf
);

  localparam logic [0:0] SHOW_A = 1'b0;
  localparam logic [0:0] SHOW_B = 1'b1;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [63:0] SIG_RST = 64'hFFFF_FFFF_FFFF_FFC0;

  logic [0:0]    state, state_d;
  logic [31:0]   a_shadow, a_shadow_d;
  logic [31:0]   b_reg, b_reg_d;
  logic [PW-1:0] presc, presc_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          tick;
  logic          b_xfer;

  logic [31:0]   word;
  logic [2:0]    msd;
  logic [63:0]   signal_d;
  logic [2:0]    n_d;
  logic          ovf_d;
  logic          blank;

  // Hex nibble to active-low segment byte
  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'h0: seg_enc = 8'hC0;
      4'h1: seg_enc = 8'hF9;
      4'h2: seg_enc = 8'hA4;
      4'h3: seg_enc = 8'hB0;
      4'h4: seg_enc = 8'h99;
      4'h5: seg_enc = 8'h92;
      4'h6: seg_enc = 8'h82;
      4'h7: seg_enc = 8'hF8;
      4'h8: seg_enc = 8'h80;
      4'h9: seg_enc = 8'h90;
      4'hA: seg_enc = 8'h88;
      4'hB: seg_enc = 8'h83;
      4'hC: seg_enc = 8'hC6;
      4'hD: seg_enc = 8'hA1;
      4'hE: seg_enc = 8'h86;
      default: seg_enc = 8'h8E;
    endcase
  endfunction

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign b_xfer = b_valid & b_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SHOW_A;
      a_shadow <= '0;
      b_reg    <= '0;
      presc    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      a_shadow <= a_shadow_d;
      b_reg    <= b_reg_d;
      presc    <= presc_d;
      hold_cnt <= hold_d;
    end
  end

  // Next-state, hold timer and capture logic
  always_comb begin
    state_d    = state;
    a_shadow_d = a_shadow;
    b_reg_d    = b_reg;
    presc_d    = tick ? '0 : presc + PW'(1);
    hold_d     = hold_cnt;

    // a_ready is constantly 1, so a_valid alone is a transfer
    if (a_valid) a_shadow_d = a_data;

    case (state)
      SHOW_A: begin
        if (b_xfer) begin
          state_d = SHOW_B;
          b_reg_d = b_data;
          presc_d = '0;
          hold_d  = '0;
        end
      end
      default: begin
        if (tick) begin
          if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
            state_d = SHOW_A;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
      end
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_off, blink_off_d;

  // Blink phase register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_d;
      blink_off <= blink_off_d;
    end
  end

  // Phase toggles every BLINK_TICKS ticks, only while B is held
  always_comb begin
    blink_cnt_d = blink_cnt;
    blink_off_d = blink_off;
    if (state_d != SHOW_B || (state == SHOW_A)) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off;
      end else begin
        blink_cnt_d = blink_cnt + BW'(1);
      end
    end
  end

  assign blank = (state == SHOW_B) & blink_off;
`else
  assign blank = 1'b0;
`endif

  // Encode the selected word with leading-zero suppression
  always_comb begin
    word = (state == SHOW_B) ? b_reg : a_shadow;
    msd  = '0;
    for (int k = 0; k < 8; k++) begin
      if (word[4*k +: 4] != 4'h0) msd = 3'(k);
    end
    signal_d = '1;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) <= msd) signal_d[8*k +: 8] = seg_enc(word[4*k +: 4]);
    end
    if (blank) signal_d = '1;
    // the scanner shows at most 7 digits; an 8th is flagged instead
    n_d   = (msd == 3'd7) ? 3'd7 : msd + 3'd1;
    ovf_d = (msd == 3'd7);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      signal  <= SIG_RST;
      n       <= 3'd1;
      src     <= 1'b0;
      ovf     <= 1'b0;
      a_ready <= 1'b1;
      b_ready <= 1'b0;
    end else begin
      signal  <= signal_d;
      n       <= n_d;
      src     <= (state == SHOW_B);
      ovf     <= ovf_d;
      a_ready <= 1'b1;
      b_ready <= (state_d == SHOW_A);
    end
  end

endmodule
